// File: rtl/pipelined_control_unit.sv
// Pipelined RV32I control unit.
// The D stage decodes the instruction. The control bundle then moves through the
// E, M and W registers. Stall holds E, flush replaces E with a bubble, and a stall
// without a flush inserts a bubble into M. The branch/jump redirect (pcsrc_e) is
// resolved in E from the E-stage ALU flags.
module pipelined_control_unit #(
  parameter bit EXT_BRANCH = 1'b1,
  parameter bit M_EXT      = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_d,
  input  logic        stall_e,
  input  logic        flush_e,
  input  logic        zero_e,
  input  logic        neg_e,
  input  logic        ovf_e,
  input  logic        carry_e,
  output logic [2:0]  immsrc_d,
  output logic        alusrc_e,
  output logic [1:0]  aluop_e,
  output logic [2:0]  funct3_e,
  output logic        funct7b5_e,
  output logic        muldiv_e,
  output logic        jalr_e,
  output logic        pcsrc_e,
  output logic [2:0]  resultsrc_e,
  output logic        memwrite_m,
  output logic [2:0]  funct3_m,
  output logic [2:0]  resultsrc_m,
  output logic [2:0]  resultsrc_w,
  output logic        regwrite_m,
  output logic        regwrite_w,
  output logic        illegal_w
);

  typedef struct packed {
    logic       regwrite;
    logic       alusrc;
    logic       memwrite;
    logic [2:0] resultsrc;
    logic       branch;
    logic [1:0] aluop;
    logic       jump;
    logic       jalr;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       muldiv;
    logic       illegal;
  } e_ctl_t;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic [2:0] resultsrc;
    logic [2:0] funct3;
    logic       illegal;
  } m_ctl_t;

  typedef struct packed {
    logic       regwrite;
    logic [2:0] resultsrc;
    logic       illegal;
  } w_ctl_t;

  logic [6:0]  op;
  logic [2:0]  funct3_d;
  logic [6:0]  funct7_d;
  logic [13:0] bundle_d;
  logic        illegal_d;
  logic        muldiv_d;
  logic        cond_e;
  e_ctl_t      e_next;
  e_ctl_t      e_reg;
  m_ctl_t      m_next;
  m_ctl_t      m_reg;
  w_ctl_t      w_reg;

  assign op       = instr_d[6:0];
  assign funct3_d = instr_d[14:12];
  assign funct7_d = instr_d[31:25];

  // Register and rd fields are not needed for control decode.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr_d[24:15], instr_d[11:7]};

  // Main decoder. Bundle order:
  // {regwrite, immsrc[2:0], alusrc, memwrite, resultsrc[2:0], branch, aluop[1:0], jump, jalr}
  always_comb begin
    bundle_d  = '0;
    illegal_d = 1'b0;
    case (op)
      7'b0000011: bundle_d = 14'b1_000_1_0_001_0_00_0_0; // load
      7'b0100011: bundle_d = 14'b0_001_1_1_000_0_00_0_0; // store
      7'b0110011: bundle_d = 14'b1_000_0_0_000_0_10_0_0; // R-type
      7'b1100011: begin                                  // branch
        if (EXT_BRANCH && (funct3_d == 3'b010 || funct3_d == 3'b011))
          illegal_d = 1'b1;
        else
          bundle_d = 14'b0_010_0_0_000_1_01_0_0;
      end
      7'b0010011: bundle_d = 14'b1_000_1_0_000_0_10_0_0; // I-type ALU
      7'b1101111: bundle_d = 14'b1_011_0_0_010_0_00_1_0; // jal
      7'b1100111: bundle_d = 14'b1_000_1_0_010_0_00_0_1; // jalr
      7'b0110111: bundle_d = 14'b1_100_0_0_011_0_00_0_0; // lui
      7'b0010111: bundle_d = 14'b1_100_0_0_100_0_00_0_0; // auipc
      default:    illegal_d = 1'b1;
    endcase
  end

  assign muldiv_d = M_EXT & (op == 7'b0110011) & (funct7_d == 7'b0000001);
  assign immsrc_d = bundle_d[12:10];

  // Repack the D decode into the fields that travel to E
  always_comb begin
    e_next.regwrite  = bundle_d[13];
    e_next.alusrc    = bundle_d[9];
    e_next.memwrite  = bundle_d[8];
    e_next.resultsrc = bundle_d[7:5];
    e_next.branch    = bundle_d[4];
    e_next.aluop     = bundle_d[3:2];
    e_next.jump      = bundle_d[1];
    e_next.jalr      = bundle_d[0];
    e_next.funct3    = funct3_d;
    e_next.funct7b5  = instr_d[30];
    e_next.muldiv    = muldiv_d;
    e_next.illegal   = illegal_d;
  end

  // E register: flush beats stall; a stalled E keeps its instruction
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      e_reg <= '0;
    else if (flush_e)
      e_reg <= '0;
    else if (!stall_e)
      e_reg <= e_next;
  end

  // Fields of E that continue on to M
  always_comb begin
    m_next.regwrite  = e_reg.regwrite;
    m_next.memwrite  = e_reg.memwrite;
    m_next.resultsrc = e_reg.resultsrc;
    m_next.funct3    = e_reg.funct3;
    m_next.illegal   = e_reg.illegal;
  end

  // M register: a held E must not also issue into M, so a bubble goes in
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      m_reg <= '0;
    else if (stall_e && !flush_e)
      m_reg <= '0;
    else
      m_reg <= m_next;
  end

  // W register: always follows M
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      w_reg <= '0;
    else
      w_reg <= '{regwrite: m_reg.regwrite, resultsrc: m_reg.resultsrc, illegal: m_reg.illegal};
  end

  // Branch condition from the flags of a-b (carry set means no borrow)
  always_comb begin
    cond_e = zero_e;
    if (EXT_BRANCH) begin
      case (e_reg.funct3)
        3'b000:  cond_e = zero_e;
        3'b001:  cond_e = !zero_e;
        3'b100:  cond_e = neg_e ^ ovf_e;
        3'b101:  cond_e = !(neg_e ^ ovf_e);
        3'b110:  cond_e = !carry_e;
        3'b111:  cond_e = carry_e;
        default: cond_e = 1'b0;
      endcase
    end
  end

  // A bubble has branch, jump and jalr clear, so it never redirects the PC.
  assign pcsrc_e     = (e_reg.branch & cond_e) | e_reg.jump | e_reg.jalr;

  assign alusrc_e    = e_reg.alusrc;
  assign aluop_e     = e_reg.aluop;
  assign funct3_e    = e_reg.funct3;
  assign funct7b5_e  = e_reg.funct7b5;
  assign muldiv_e    = e_reg.muldiv;
  assign jalr_e      = e_reg.jalr;
  assign resultsrc_e = e_reg.resultsrc;
  assign memwrite_m  = m_reg.memwrite;
  assign funct3_m    = m_reg.funct3;
  assign resultsrc_m = m_reg.resultsrc;
  assign regwrite_m  = m_reg.regwrite;
  assign resultsrc_w = w_reg.resultsrc;
  assign regwrite_w  = w_reg.regwrite;
  assign illegal_w   = w_reg.illegal;

endmodule
